gpu_banked_register_file: RTL and testbench



---
 rtl/gpu_rf_pkg.sv | 32 +++
 rtl/gpu_rf_bank.sv | 53 +++++
 rtl/gpu_banked_register_file.sv | 180 ++++++++++++++++++
 tb/tb_gpu_banked_register_file.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_rf_pkg.sv
// Shared types and helpers for the banked multi-context GPU register file.
// Helpers work on a fixed maximum width so any DATA_WIDTH up to RF_MAX_DW can use them.
package gpu_rf_pkg;

  localparam int unsigned RF_MAX_DW = 256;
  localparam int unsigned RF_MAX_BE = RF_MAX_DW / 8;

  typedef enum logic [0:0] {
    RF_IDLE   = 1'b0,
    RF_SECOND = 1'b1
  } rf_state_e;

  function automatic logic [31:0] bank_of(input logic [31:0] addr, input logic [31:0] num_banks);
    return addr & (num_banks - 32'd1);
  endfunction

  function automatic logic [RF_MAX_DW-1:0] merge_be(input logic [RF_MAX_DW-1:0] old_v,
                                                     input logic [RF_MAX_DW-1:0] new_v,
                                                     input logic [RF_MAX_BE-1:0] be);
    logic [RF_MAX_DW-1:0] res;
    res = old_v;
    for (int k = 0; k < int'(RF_MAX_BE); k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gpu_rf_bank.sv
// One storage bank: synchronous 1R1W array with byte-enable writes and
// same-cycle write-to-read forwarding into the registered read data.
module gpu_rf_bank import gpu_rf_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ROW_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_rd_en,
  input  logic [ROW_W-1:0]        i_rd_row,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  input  logic                    i_wr_en,
  input  logic [ROW_W-1:0]        i_wr_row,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_rd_next;

  // A read of the row being written sees the merged post-write value
  always_comb begin
    w_wr_merged = DATA_WIDTH'(merge_be(RF_MAX_DW'(r_mem[i_wr_row]), RF_MAX_DW'(i_wr_data),
                                       RF_MAX_BE'(i_wr_be)));
    if (i_wr_en && (i_wr_row == i_rd_row)) begin
      w_rd_next = w_wr_merged;
    end else begin
      w_rd_next = r_mem[i_rd_row];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[i_wr_row] <= w_wr_merged;
      end
      if (i_rd_en) begin
        r_rd_data <= w_rd_next;
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gpu_banked_register_file.sv
// Multi-context banked register file: two-operand reads with valid/ready,
// bank conflicts serialised over two cycles, never-stalling byte-enabled writes.
module gpu_banked_register_file import gpu_rf_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int NUM_THREADS = 4,
  parameter int NUM_BANKS   = 4,
  parameter int ZERO_REG    = 1,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int TID_WIDTH   = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_rd_valid,
  output logic                    o_rd_ready,
  input  logic [TID_WIDTH-1:0]    i_rd_tid,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr_a,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr_b,
  output logic                    o_rd_valid,
  output logic [DATA_WIDTH-1:0]   o_rd_data_a,
  output logic [DATA_WIDTH-1:0]   o_rd_data_b,
  input  logic                    i_wr_en,
  input  logic [TID_WIDTH-1:0]    i_wr_tid,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  output logic                    o_conflict
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = TID_WIDTH + ADDR_WIDTH - BANK_W;
  localparam int DEPTH  = NUM_THREADS * NUM_REGS / NUM_BANKS;

  rf_state_e             r_state;
  logic [TID_WIDTH-1:0]  r_cap_tid;
  logic [ADDR_WIDTH-1:0] r_cap_addr_b;
  logic [BANK_W-1:0]     r_cap_bank;
  logic [DATA_WIDTH-1:0] r_cap_a;
  logic                  r_out_valid;
  logic                  r_use_cap;
  logic                  r_zero_a;
  logic                  r_zero_b;
  logic [BANK_W-1:0]     r_sel_a;
  logic [BANK_W-1:0]     r_sel_b;
  logic [DATA_WIDTH-1:0] r_hold_a;
  logic [DATA_WIDTH-1:0] r_hold_b;

  logic [BANK_W-1:0]     w_bank_a;
  logic [BANK_W-1:0]     w_bank_b;
  logic [BANK_W-1:0]     w_bank_wr;
  logic                  w_zero_a;
  logic                  w_zero_b;
  logic                  w_zero_wr;
  logic                  w_conflict;
  logic                  w_accept;
  logic [ROW_W-1:0]      w_wr_row;
  logic                  w_rd_en   [NUM_BANKS];
  logic [ROW_W-1:0]      w_rd_row  [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_bank_data [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_data_a;
  logic [DATA_WIDTH-1:0] w_data_b;

  // Register 0 (when hard-wired) is never a bank access, so it can never conflict
  always_comb begin
    w_bank_a   = BANK_W'(bank_of(32'(i_rd_addr_a), 32'(NUM_BANKS)));
    w_bank_b   = BANK_W'(bank_of(32'(i_rd_addr_b), 32'(NUM_BANKS)));
    w_bank_wr  = BANK_W'(bank_of(32'(i_wr_addr), 32'(NUM_BANKS)));
    w_zero_a   = (ZERO_REG != 0) && (i_rd_addr_a == '0);
    w_zero_b   = (ZERO_REG != 0) && (i_rd_addr_b == '0);
    w_zero_wr  = (ZERO_REG != 0) && (i_wr_addr == '0);
    w_conflict = !w_zero_a && !w_zero_b && (w_bank_a == w_bank_b) && (i_rd_addr_a != i_rd_addr_b);
    w_accept   = i_rd_valid && (r_state == RF_IDLE);
    w_wr_row   = {i_wr_tid, i_wr_addr[ADDR_WIDTH-1:BANK_W]};
  end

  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_rd_en[k]  = 1'b0;
      w_rd_row[k] = '0;
    end
    if (r_state == RF_SECOND) begin
      w_rd_en[r_cap_bank]  = 1'b1;
      w_rd_row[r_cap_bank] = {r_cap_tid, r_cap_addr_b[ADDR_WIDTH-1:BANK_W]};
    end else if (w_accept) begin
      if (!w_zero_a) begin
        w_rd_en[w_bank_a]  = 1'b1;
        w_rd_row[w_bank_a] = {i_rd_tid, i_rd_addr_a[ADDR_WIDTH-1:BANK_W]};
      end
      // a == b lands on the same bank/row, so one read serves both operands
      if (!w_zero_b && !w_conflict) begin
        w_rd_en[w_bank_b]  = 1'b1;
        w_rd_row[w_bank_b] = {i_rd_tid, i_rd_addr_b[ADDR_WIDTH-1:BANK_W]};
      end
    end else begin
      w_rd_en[0] = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    gpu_rf_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_en   (w_rd_en[g]),
      .i_rd_row  (w_rd_row[g]),
      .o_rd_data (w_bank_data[g]),
      .i_wr_en   (i_wr_en && !w_zero_wr && (w_bank_wr == BANK_W'(g))),
      .i_wr_row  (w_wr_row),
      .i_wr_data (i_wr_data),
      .i_wr_be   (i_wr_be)
    );
  end

  always_comb begin
    w_data_a = r_zero_a ? '0 : (r_use_cap ? r_cap_a : w_bank_data[r_sel_a]);
    w_data_b = r_zero_b ? '0 : w_bank_data[r_sel_b];
  end

  assign o_rd_valid  = r_out_valid;
  assign o_rd_data_a = r_out_valid ? w_data_a : r_hold_a;
  assign o_rd_data_b = r_out_valid ? w_data_b : r_hold_b;
  assign o_rd_ready  = (r_state == RF_IDLE);
  assign o_conflict  = w_accept && w_conflict;

  // Operand A is captured on leaving SECOND, before the B read overwrites the shared bank output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RF_IDLE;
      r_cap_tid    <= '0;
      r_cap_addr_b <= '0;
      r_cap_bank   <= '0;
      r_cap_a      <= '0;
      r_out_valid  <= 1'b0;
      r_use_cap    <= 1'b0;
      r_zero_a     <= 1'b0;
      r_zero_b     <= 1'b0;
      r_sel_a      <= '0;
      r_sel_b      <= '0;
      r_hold_a     <= '0;
      r_hold_b     <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_out_valid) begin
        r_hold_a <= w_data_a;
        r_hold_b <= w_data_b;
      end
      case (r_state)
        RF_IDLE: begin
          if (w_accept && w_conflict) begin
            r_state      <= RF_SECOND;
            r_cap_tid    <= i_rd_tid;
            r_cap_addr_b <= i_rd_addr_b;
            r_cap_bank   <= w_bank_a;
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_sel_a     <= w_bank_a;
            r_sel_b     <= w_bank_b;
            r_zero_a    <= w_zero_a;
            r_zero_b    <= w_zero_b;
            r_use_cap   <= 1'b0;
          end
        end
        RF_SECOND: begin
          r_cap_a     <= w_bank_data[r_cap_bank];
          r_out_valid <= 1'b1;
          r_sel_b     <= r_cap_bank;
          r_zero_a    <= 1'b0;
          r_zero_b    <= 1'b0;
          r_use_cap   <= 1'b1;
          r_state     <= RF_IDLE;
        end
        default: r_state <= RF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_banked_register_file.sv
// Self-checking bench: directed vector table, hand-written multi-cycle sequences,
// then random traffic against a cycle-level reference model of the register file.
module tb_gpu_banked_register_file;

  logic        clk;
  logic        rst_n;
  logic        i_rd_valid;
  logic        o_rd_ready;
  logic [1:0]  i_rd_tid;
  logic [4:0]  i_rd_addr_a;
  logic [4:0]  i_rd_addr_b;
  logic        o_rd_valid;
  logic [31:0] o_rd_data_a;
  logic [31:0] o_rd_data_b;
  logic        i_wr_en;
  logic [1:0]  i_wr_tid;
  logic [4:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic [3:0]  i_wr_be;
  logic        o_conflict;

  gpu_banked_register_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_valid  (i_rd_valid),
    .o_rd_ready  (o_rd_ready),
    .i_rd_tid    (i_rd_tid),
    .i_rd_addr_a (i_rd_addr_a),
    .i_rd_addr_b (i_rd_addr_b),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data_a (o_rd_data_a),
    .o_rd_data_b (o_rd_data_b),
    .i_wr_en     (i_wr_en),
    .i_wr_tid    (i_wr_tid),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_wr_be     (i_wr_be),
    .o_conflict  (o_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_tid;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [1:0]  rd_tid;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        exp_conf;
    int          exp_lat;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [16];
  int   total;
  int   bad;

  // reference model state
  logic [31:0] m_mem [4][32];
  logic        m_pending;
  logic        m_valid;
  logic [31:0] m_cap_a;
  logic [1:0]  m_p_tid;
  logic [4:0]  m_p_b;
  logic [31:0] m_last_a;
  logic [31:0] m_last_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic we, input logic [1:0] wt, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [3:0] wbe,
                               input logic re, input logic [1:0] rt, input logic [4:0] a,
                               input logic [4:0] b, input logic ec, input int el,
                               input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.wr_en = we; v.wr_tid = wt; v.wr_addr = wa; v.wr_data = wd; v.wr_be = wbe;
    v.rd_en = re; v.rd_tid = rt; v.ra = a; v.rb = b;
    v.exp_conf = ec; v.exp_lat = el; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  function automatic logic is_conf(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (b != 5'd0) && (a[1:0] == b[1:0]) && (a != b);
  endfunction

  function automatic logic [31:0] rdm(input logic [1:0] t, input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_mem[t][a];
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    i_wr_en = v.wr_en; i_wr_tid = v.wr_tid; i_wr_addr = v.wr_addr;
    i_wr_data = v.wr_data; i_wr_be = v.wr_be;
    i_rd_valid = v.rd_en; i_rd_tid = v.rd_tid; i_rd_addr_a = v.ra; i_rd_addr_b = v.rb;
    #1;
    if (v.rd_en) begin
      chk("vec_ready", 32'(o_rd_ready), 32'd1);
      chk("vec_conflict", 32'(o_conflict), 32'(v.exp_conf));
    end
    @(negedge clk);
    i_wr_en = 1'b0;
    i_rd_valid = 1'b0;
    if (v.rd_en) begin
      lat = 1;
      while ((o_rd_valid !== 1'b1) && (lat < 6)) begin
        @(negedge clk);
        lat++;
      end
      chk("vec_latency", 32'(lat), 32'(v.exp_lat));
      chk("vec_data_a", o_rd_data_a, v.exp_a);
      chk("vec_data_b", o_rd_data_b, v.exp_b);
      @(negedge clk);
      chk("vec_pulse_len", 32'(o_rd_valid), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic cf;
    total = 0; bad = 0;
    rst_n = 1'b0;
    i_rd_valid = 1'b0; i_rd_tid = 2'd0; i_rd_addr_a = 5'd0; i_rd_addr_b = 5'd0;
    i_wr_en = 1'b0; i_wr_tid = 2'd0; i_wr_addr = 5'd0; i_wr_data = 32'd0; i_wr_be = 4'd0;

    vecs[0]  = mkv(1'b0, 2'd0, 5'd0, 32'h0,        4'h0, 1'b1, 2'd0, 5'd1, 5'd2, 1'b0, 1, 32'h0,        32'h0);
    vecs[1]  = mkv(1'b1, 2'd1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1, 32'h0,        32'h0);
    vecs[2]  = mkv(1'b0, 2'd0, 5'd0, 32'h0,        4'h0, 1'b1, 2'd1, 5'd5, 5'd6, 1'b0, 1, 32'hDEADBEEF, 32'h0);
    vecs[3]  = mkv(1'b0, 2'd0, 5'd0, 32'h0,        4'h0, 1'b1, 2'd0, 5'd5, 5'd6, 1'b0, 1, 32'h0,        32'h0);
    vecs[4]  = mkv(1'b1, 2'd0, 5'd1, 32'h11,       4'hF, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1, 32'h0,        32'h0);
    vecs[5]  = mkv(1'b1, 2'd0, 5'd5, 32'h55,       4'hF, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1, 32'h0,        32'h0);
    vecs[6]  = mkv(1'b0, 2'd0, 5'd0, 32'h0,        4'h0, 1'b1, 2'd0, 5'd1, 5'd5, 1'b1, 2, 32'h11,       32'h55);
    vecs[7]  = mkv(1'b1, 2'd0, 5'd3, 32'hAABBCCDD, 4'hF, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1, 32'h0,        32'h0);
    vecs[8]  = mkv(1'b1, 2'd0, 5'd3, 32'h11223344, 4'h3, 1'b1, 2'd0, 5'd3, 5'd0, 1'b0, 1, 32'hAABB3344, 32'h0);
    vecs[9]  = mkv(1'b1, 2'd0, 5'd4, 32'h44,       4'hF, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1, 32'h0,        32'h0);
    vecs[10] = mkv(1'b1, 2'd0, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1, 32'h0,        32'h0);
    vecs[11] = mkv(1'b0, 2'd0, 5'd0, 32'h0,        4'h0, 1'b1, 2'd0, 5'd0, 5'd4, 1'b0, 1, 32'h0,        32'h44);
    vecs[12] = mkv(1'b0, 2'd0, 5'd0, 32'h0,        4'h0, 1'b1, 2'd0, 5'd4, 5'd4, 1'b0, 1, 32'h44,       32'h44);
    vecs[13] = mkv(1'b1, 2'd0, 5'd1, 32'hFFFFFFFF, 4'h0, 1'b1, 2'd0, 5'd1, 5'd2, 1'b0, 1, 32'h11,       32'h0);
    vecs[14] = mkv(1'b0, 2'd0, 5'd0, 32'h0,        4'h0, 1'b1, 2'd1, 5'd1, 5'd5, 1'b1, 2, 32'h0,        32'hDEADBEEF);
    vecs[15] = mkv(1'b0, 2'd0, 5'd0, 32'h0,        4'h0, 1'b1, 2'd0, 5'd0, 5'd0, 1'b0, 1, 32'h0,        32'h0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(o_rd_ready), 32'd1);
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_data_a", o_rd_data_a, 32'd0);
    chk("rst_data_b", o_rd_data_b, 32'd0);
    chk("rst_conflict", 32'(o_conflict), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i]);
    end

    // conflicted request followed by a second request held valid through SECOND
    @(negedge clk);
    i_rd_valid = 1'b1; i_rd_tid = 2'd0; i_rd_addr_a = 5'd1; i_rd_addr_b = 5'd5;
    #1 chk("b2b_conflict", 32'(o_conflict), 32'd1);
    @(negedge clk);
    i_rd_tid = 2'd1; i_rd_addr_a = 5'd5; i_rd_addr_b = 5'd6;
    #1;
    chk("b2b_second_ready", 32'(o_rd_ready), 32'd0);
    chk("b2b_second_conf", 32'(o_conflict), 32'd0);
    chk("b2b_second_valid", 32'(o_rd_valid), 32'd0);
    @(negedge clk);
    chk("b2b_first_valid", 32'(o_rd_valid), 32'd1);
    chk("b2b_first_a", o_rd_data_a, 32'h11);
    chk("b2b_first_b", o_rd_data_b, 32'h55);
    chk("b2b_ready_back", 32'(o_rd_ready), 32'd1);
    @(negedge clk);
    i_rd_valid = 1'b0;
    chk("b2b_second_req_valid", 32'(o_rd_valid), 32'd1);
    chk("b2b_second_req_a", o_rd_data_a, 32'hDEADBEEF);
    chk("b2b_second_req_b", o_rd_data_b, 32'h0);
    @(negedge clk);
    chk("b2b_idle_valid", 32'(o_rd_valid), 32'd0);
    chk("b2b_hold_a", o_rd_data_a, 32'hDEADBEEF);

    // byte-enabled write forwarded into the B read of SECOND
    i_rd_valid = 1'b1; i_rd_tid = 2'd0; i_rd_addr_a = 5'd1; i_rd_addr_b = 5'd5;
    @(negedge clk);
    i_rd_valid = 1'b0;
    i_wr_en = 1'b1; i_wr_tid = 2'd0; i_wr_addr = 5'd5; i_wr_data = 32'h12345678; i_wr_be = 4'hC;
    @(negedge clk);
    i_wr_en = 1'b0;
    chk("fwd2_valid", 32'(o_rd_valid), 32'd1);
    chk("fwd2_a", o_rd_data_a, 32'h11);
    chk("fwd2_b", o_rd_data_b, 32'h12340055);

    // reset while in SECOND abandons the request and clears storage
    @(negedge clk);
    i_rd_valid = 1'b1; i_rd_tid = 2'd0; i_rd_addr_a = 5'd1; i_rd_addr_b = 5'd5;
    @(negedge clk);
    i_rd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_ready", 32'(o_rd_ready), 32'd1);
    chk("rst2_valid", 32'(o_rd_valid), 32'd0);
    chk("rst2_data_a", o_rd_data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst2_no_pulse", 32'(o_rd_valid), 32'd0);
      @(negedge clk);
    end
    run_vec(mkv(1'b0, 2'd0, 5'd0, 32'h0, 4'h0, 1'b1, 2'd0, 5'd1, 5'd5, 1'b1, 2, 32'h0, 32'h0));

    // randomized traffic against the reference model
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[t][r] = 32'd0;
      end
    end
    m_pending = 1'b0; m_valid = 1'b0; m_cap_a = 32'd0; m_p_tid = 2'd0; m_p_b = 5'd0;
    m_last_a = 32'd0; m_last_b = 32'd0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      chk("rnd_valid", 32'(o_rd_valid), 32'(m_valid));
      chk("rnd_data_a", o_rd_data_a, m_last_a);
      chk("rnd_data_b", o_rd_data_b, m_last_b);
      i_wr_en     = ($urandom_range(0, 1) == 1);
      i_wr_tid    = 2'($urandom_range(0, 1));
      i_wr_addr   = 5'($urandom_range(0, 9));
      i_wr_data   = $urandom;
      i_wr_be     = 4'($urandom_range(0, 15));
      i_rd_valid  = ($urandom_range(0, 3) != 0);
      i_rd_tid    = 2'($urandom_range(0, 1));
      i_rd_addr_a = 5'($urandom_range(0, 9));
      i_rd_addr_b = 5'($urandom_range(0, 9));
      cf = is_conf(i_rd_addr_a, i_rd_addr_b);
      #1;
      chk("rnd_ready", 32'(o_rd_ready), 32'(!m_pending));
      chk("rnd_conflict", 32'(o_conflict), 32'(i_rd_valid && !m_pending && cf));
      @(posedge clk);
      if (i_wr_en && (i_wr_addr != 5'd0)) begin
        for (int k = 0; k < 4; k++) begin
          if (i_wr_be[k]) m_mem[i_wr_tid][i_wr_addr][8*k +: 8] = i_wr_data[8*k +: 8];
        end
      end
      m_valid = 1'b0;
      if (m_pending) begin
        m_last_a  = m_cap_a;
        m_last_b  = rdm(m_p_tid, m_p_b);
        m_valid   = 1'b1;
        m_pending = 1'b0;
      end else if (i_rd_valid) begin
        if (cf) begin
          m_cap_a   = rdm(i_rd_tid, i_rd_addr_a);
          m_p_tid   = i_rd_tid;
          m_p_b     = i_rd_addr_b;
          m_pending = 1'b1;
        end else begin
          m_last_a = rdm(i_rd_tid, i_rd_addr_a);
          m_last_b = rdm(i_rd_tid, i_rd_addr_b);
          m_valid  = 1'b1;
        end
      end
    end
    @(negedge clk);
    i_wr_en = 1'b0;
    i_rd_valid = 1'b0;
    chk("rnd_final_valid", 32'(o_rd_valid), 32'(m_valid));
    chk("rnd_final_a", o_rd_data_a, m_last_a);
    chk("rnd_final_b", o_rd_data_b, m_last_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
